// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU encodings, MIPS opcode/funct values, issue bundle and slot state types
package alu_pkg;
  localparam int XLEN = 32;
  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_OR      = 4'b0010;
  localparam logic [3:0] ALU_NOR     = 4'b0011;
  localparam logic [3:0] ALU_AND     = 4'b0100;
  localparam logic [3:0] ALU_NAND    = 4'b0101;
  localparam logic [3:0] ALU_XOR     = 4'b0110;
  localparam logic [3:0] ALU_SLL     = 4'b0111;
  localparam logic [3:0] ALU_SRL     = 4'b1000;
  localparam logic [3:0] ALU_SRA     = 4'b1001;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  typedef struct packed {
    logic [3:0]      aluop;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      dest;
    logic            wr_en;
    logic            illegal;
  } issue_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} slot_state_t;
endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: upstream (ID) and downstream (EX) handshake bundles of the issue stage
interface alu_issue_in_if;
  import alu_pkg::*;
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  modport master (output in_valid, flush, instr, rs_data, rt_data, input in_ready);
  modport slave  (input in_valid, flush, instr, rs_data, rt_data, output in_ready);
endinterface

interface alu_issue_out_if;
  import alu_pkg::*;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      aluop;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      dest;
  logic            wr_en;
  logic            illegal;
  modport master (output out_valid, aluop, op_a, op_b, dest, wr_en, illegal, input out_ready);
  modport slave  (input out_valid, aluop, op_a, op_b, dest, wr_en, illegal, output out_ready);
endinterface

// File: rtl/alu_decode.sv
// alu_decode: maps a MIPS instruction and its register operands onto an ALU issue bundle
module alu_decode import alu_pkg::*; (
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_rs_data,
  input  logic [XLEN-1:0] i_rt_data,
  output issue_t          o_bundle
);
  logic [5:0]      w_opc, w_funct;
  logic [4:0]      w_rt, w_rd, w_shamt, w_dst;
  logic [XLEN-1:0] w_sext, w_zext, w_a, w_b;
  logic [3:0]      w_op;
  logic            w_ok, w_wr, w_we, w_unused;
  assign w_opc    = i_instr[31:26];
  assign w_rt     = i_instr[20:16];
  assign w_rd     = i_instr[15:11];
  assign w_shamt  = i_instr[10:6];
  assign w_funct  = i_instr[5:0];
  assign w_sext   = {{(XLEN-16){i_instr[15]}}, i_instr[15:0]};
  assign w_zext   = {{(XLEN-16){1'b0}}, i_instr[15:0]};
  assign w_unused = ^i_instr[25:21];
  // Choose operation, operand slots and write-back target from opcode/funct
  always_comb begin
    w_ok  = 1'b1;
    w_op  = ALU_ADD;
    w_a   = i_rs_data;
    w_b   = i_rt_data;
    w_dst = w_rd;
    w_wr  = 1'b1;
    case (w_opc)
      OP_RTYPE: case (w_funct)
        F_ADD, F_ADDU: w_op = ALU_ADD;
        F_SUB, F_SUBU: w_op = ALU_SUB;
        F_AND:         w_op = ALU_AND;
        F_OR:          w_op = ALU_OR;
        F_XOR:         w_op = ALU_XOR;
        F_NOR:         w_op = ALU_NOR;
        F_SLL:  begin w_op = ALU_SLL; w_a = {{(XLEN-5){1'b0}}, w_shamt}; end
        F_SRL:  begin w_op = ALU_SRL; w_a = {{(XLEN-5){1'b0}}, w_shamt}; end
        F_SRA:  begin w_op = ALU_SRA; w_a = {{(XLEN-5){1'b0}}, w_shamt}; end
        F_SLLV: begin w_op = ALU_SLL; w_a = {{(XLEN-5){1'b0}}, i_rs_data[4:0]}; end
        F_SRLV: begin w_op = ALU_SRL; w_a = {{(XLEN-5){1'b0}}, i_rs_data[4:0]}; end
        F_SRAV: begin w_op = ALU_SRA; w_a = {{(XLEN-5){1'b0}}, i_rs_data[4:0]}; end
        default:       w_ok = 1'b0;
      endcase
      OP_ADDI, OP_ADDIU, OP_LW: begin w_b = w_sext; w_dst = w_rt; end
      OP_SW:            begin w_b = w_sext; w_dst = w_rt; w_wr = 1'b0; end
      OP_ANDI:          begin w_op = ALU_AND; w_b = w_zext; w_dst = w_rt; end
      OP_ORI:           begin w_op = ALU_OR; w_b = w_zext; w_dst = w_rt; end
      OP_XORI:          begin w_op = ALU_XOR; w_b = w_zext; w_dst = w_rt; end
      OP_BEQ, OP_BNE:   begin w_op = ALU_SUB; w_dst = w_rt; w_wr = 1'b0; end
      OP_LUI:           begin w_op = ALU_SLL; w_a = XLEN'(16); w_b = w_zext; w_dst = w_rt; end
      default:          w_ok = 1'b0;
    endcase
  end
  assign w_we = w_ok && w_wr && (w_dst != 5'd0);
  // Illegal encodings still flow as an inert bundle; dest reads 0 whenever nothing is written
  always_comb begin
    o_bundle.aluop   = w_ok ? w_op : ALU_ILLEGAL;
    o_bundle.op_a    = w_ok ? w_a : '0;
    o_bundle.op_b    = w_ok ? w_b : '0;
    o_bundle.dest    = w_we ? w_dst : 5'd0;
    o_bundle.wr_en   = w_we;
    o_bundle.illegal = !w_ok;
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes into an issue bundle and registers it toward EX through a main/skid slot pair
module alu_issue_stage import alu_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  alu_issue_in_if.slave    up,
  alu_issue_out_if.master  dn
);
  slot_state_t r_state, w_next;
  issue_t      r_main, r_skid, w_dec;
  logic        r_in_ready, w_in_fire, w_out_fire, w_out_valid;
  logic        w_load_main, w_load_skid, w_skid_to_main;
  alu_decode u_decode (
    .i_instr   (up.instr),
    .i_rs_data (up.rs_data),
    .i_rt_data (up.rt_data),
    .o_bundle  (w_dec)
  );
  assign w_out_valid = r_state != EMPTY;
  assign w_in_fire   = up.in_valid && r_in_ready;
  assign w_out_fire  = w_out_valid && dn.out_ready;
  // Slot occupancy transitions; flush wins over any same-cycle transfer
  always_comb begin
    w_next         = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (up.flush) w_next = EMPTY;
    else case (r_state)
      EMPTY: begin
        w_next      = w_in_fire ? ONE : EMPTY;
        w_load_main = w_in_fire;
      end
      ONE: begin
        w_next      = w_in_fire && !w_out_fire ? FULL : (!w_in_fire && w_out_fire ? EMPTY : ONE);
        w_load_main = w_in_fire && w_out_fire;
        w_load_skid = w_in_fire && !w_out_fire;
      end
      FULL: begin
        w_next         = w_out_fire ? ONE : FULL;
        w_skid_to_main = w_out_fire;
      end
      default: w_next = EMPTY;
    endcase
  end
  // Slot registers; in_ready is registered from the next state so it never sees out_ready combinationally
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= w_next != FULL;
      if (w_load_main) r_main <= w_dec;
      else if (w_skid_to_main) r_main <= r_skid;
      if (w_load_skid) r_skid <= w_dec;
    end
  end
  assign up.in_ready  = r_in_ready;
  assign dn.out_valid = w_out_valid;
  assign dn.aluop     = r_main.aluop;
  assign dn.op_a      = r_main.op_a;
  assign dn.op_b      = r_main.op_b;
  assign dn.dest      = r_main.dest;
  assign dn.wr_en     = r_main.wr_en;
  assign dn.illegal   = r_main.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: table-driven vectors through a scoreboard, plus backpressure, flush and reset sequences
module tb_alu_issue_stage;
  import alu_pkg::*;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    issue_t      exp;
  } vec_t;
  localparam int N = 17;
  logic clk = 1'b0;
  logic reset;
  logic rnd;
  logic acc;
  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  vec_t tbl [N];
  issue_t q [$];
  issue_t cur_exp;
  issue_t got;
  alu_issue_in_if  u ();
  alu_issue_out_if d ();
  alu_issue_stage dut (.clk(clk), .reset(reset), .up(u), .dn(d));
  always #5 clk = ~clk;
  function automatic vec_t mk(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt, logic [3:0] op,
                              logic [31:0] a, logic [31:0] b, logic [4:0] dst, logic we, logic ill);
    vec_t v;
    v.instr = ins;
    v.rs = rs;
    v.rt = rt;
    v.exp = '{aluop: op, op_a: a, op_b: b, dest: dst, wr_en: we, illegal: ill};
    return v;
  endfunction
  task automatic check(input string nm, input logic [127:0] g, input logic [127:0] e);
    total++;
    if (g === e) passed++;
    else $display("FAIL %s: got %h expected %h", nm, g, e);
  endtask
  function automatic issue_t cur_out();
    issue_t b;
    b = '{aluop: d.aluop, op_a: d.op_a, op_b: d.op_b, dest: d.dest, wr_en: d.wr_en, illegal: d.illegal};
    return b;
  endfunction
  task automatic step();
    @(negedge clk);
    acc = u.in_valid && u.in_ready && !u.flush && !reset;
    if (d.out_valid && d.out_ready) begin
      got = cur_out();
      if (q.size() == 0) begin
        total++;
        $display("FAIL extra_bundle: got %h expected none", got);
      end else check("bundle", got, q.pop_front());
    end
    if (reset || u.flush) q.delete();
    else if (acc) q.push_back(cur_exp);
    @(posedge clk);
    #1;
    cyc++;
    if (rnd) d.out_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic drive(input int k);
    u.in_valid = 1'b1;
    u.instr = tbl[k].instr;
    u.rs_data = tbl[k].rs;
    u.rt_data = tbl[k].rt;
    cur_exp = tbl[k].exp;
  endtask
  task automatic wait_accept(input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      ok = acc;
    end
    if (!ok) check(nm, 0, 1);
    u.in_valid = 1'b0;
  endtask
  task automatic send(input int k);
    drive(k);
    wait_accept("accept_timeout");
  endtask
  task automatic drain(input string nm);
    for (int i = 0; i < 200 && q.size() != 0; i++) step();
    check(nm, q.size(), 0);
  endtask
  initial begin
    tbl[0]  = mk(32'h2022FFFF, 32'd5, 32'h77, ALU_ADD, 32'd5, 32'hFFFFFFFF, 5'd2, 1'b1, 1'b0);
    tbl[1]  = mk(32'h00041903, 32'h12345678, 32'h80000000, ALU_SRA, 32'd4, 32'h80000000, 5'd3, 1'b1, 1'b0);
    tbl[2]  = mk(32'h3C051234, 32'hAAAA5555, 32'h1, ALU_SLL, 32'd16, 32'h00001234, 5'd5, 1'b1, 1'b0);
    tbl[3]  = mk(32'hFC000000, 32'hDEADBEEF, 32'hCAFEF00D, ALU_ILLEGAL, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    tbl[4]  = mk(32'h01093822, 32'd100, 32'd30, ALU_SUB, 32'd100, 32'd30, 5'd7, 1'b1, 1'b0);
    tbl[5]  = mk(32'h00225027, 32'hF0F0F0F0, 32'h0F0F0000, ALU_NOR, 32'hF0F0F0F0, 32'h0F0F0000, 5'd10, 1'b1, 1'b0);
    tbl[6]  = mk(32'h018D5806, 32'hFFFFFFE5, 32'hABCD0000, ALU_SRL, 32'd5, 32'hABCD0000, 5'd11, 1'b1, 1'b0);
    tbl[7]  = mk(32'h30648001, 32'h0000FFFF, 32'd0, ALU_AND, 32'h0000FFFF, 32'h00008001, 5'd4, 1'b1, 1'b0);
    tbl[8]  = mk(32'h8FA6FFFC, 32'h00001000, 32'd3, ALU_ADD, 32'h00001000, 32'hFFFFFFFC, 5'd6, 1'b1, 1'b0);
    tbl[9]  = mk(32'hAFA60008, 32'h00002000, 32'd3, ALU_ADD, 32'h00002000, 32'd8, 5'd0, 1'b0, 1'b0);
    tbl[10] = mk(32'h10220010, 32'd9, 32'd9, ALU_SUB, 32'd9, 32'd9, 5'd0, 1'b0, 1'b0);
    tbl[11] = mk(32'h00220020, 32'd1, 32'd2, ALU_ADD, 32'd1, 32'd2, 5'd0, 1'b0, 1'b0);
    tbl[12] = mk(32'h00220801, 32'd1, 32'd2, ALU_ILLEGAL, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    tbl[13] = mk(32'h3909FFFF, 32'h12345678, 32'd0, ALU_XOR, 32'h12345678, 32'h0000FFFF, 5'd9, 1'b1, 1'b0);
    tbl[14] = mk(32'h340300FF, 32'd0, 32'd7, ALU_OR, 32'd0, 32'h000000FF, 5'd3, 1'b1, 1'b0);
    tbl[15] = mk(32'h00020FC0, 32'h0000DEAD, 32'd1, ALU_SLL, 32'd31, 32'd1, 5'd1, 1'b1, 1'b0);
    tbl[16] = mk(32'h00641024, 32'hFF00FF00, 32'h0FF00FF0, ALU_AND, 32'hFF00FF00, 32'h0FF00FF0, 5'd2, 1'b1, 1'b0);
    reset = 1'b1;
    rnd = 1'b0;
    acc = 1'b0;
    cur_exp = '0;
    u.in_valid = 1'b0;
    u.flush = 1'b0;
    u.instr = '0;
    u.rs_data = '0;
    u.rt_data = '0;
    d.out_ready = 1'b0;
    step();
    step();
    check("rst_out_valid", d.out_valid, 0);
    check("rst_in_ready", u.in_ready, 1);
    check("rst_bundle", cur_out(), 0);
    reset = 1'b0;
    d.out_ready = 1'b1;
    send(0);
    check("latency", d.out_valid, 1);
    begin
      int t0;
      t0 = cyc;
      for (int k = 1; k < N; k++) send(k);
      check("throughput", cyc - t0, N - 1);
    end
    drain("drain_stream");
    rnd = 1'b1;
    for (int k = 0; k < N; k++) send(k);
    drain("drain_random");
    rnd = 1'b0;
    d.out_ready = 1'b0;
    step();
    check("idle_out_valid", d.out_valid, 0);
    send(4);
    check("a_in_ready", u.in_ready, 1);
    send(5);
    check("b_full_in_ready", u.in_ready, 0);
    drive(6);
    for (int i = 0; i < 3; i++) begin
      step();
      check("c_held_in_ready", u.in_ready, 0);
      check("hold_bundle", cur_out(), tbl[4].exp);
    end
    d.out_ready = 1'b1;
    wait_accept("c_accept");
    drain("abc_drain");
    step();
    check("abc_no_dup", d.out_valid, 0);
    d.out_ready = 1'b0;
    send(7);
    send(8);
    check("full_before_flush", u.in_ready, 0);
    drive(9);
    u.flush = 1'b1;
    step();
    u.flush = 1'b0;
    u.in_valid = 1'b0;
    check("flush_out_valid", d.out_valid, 0);
    check("flush_in_ready", u.in_ready, 1);
    d.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("flush_no_bundle", d.out_valid, 0);
    end
    d.out_ready = 1'b0;
    send(10);
    check("one_before_reset", d.out_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset_out_valid", d.out_valid, 0);
    check("reset_in_ready", u.in_ready, 1);
    check("reset_bundle", cur_out(), 0);
    d.out_ready = 1'b1;
    step();
    check("reset_no_bundle", d.out_valid, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
